// File: rtl/orb_m16_if.sv
// Five-channel RS-485 bus between the orb_m16 master and its slave boards.
// Bit n of each vector belongs to channel n.
interface orb_m16_if;
  logic [5:1] UART_RX;
  logic [5:1] UART_TX;
  logic [5:1] UART_dTX;
  logic [5:1] UART_dRX;

  modport master (
    input  UART_RX,
    output UART_TX,
    output UART_dTX,
    output UART_dRX
  );

  modport slave (
    output UART_RX,
    input  UART_TX,
    input  UART_dTX,
    input  UART_dRX
  );
endinterface

// File: rtl/orb_m16.sv
// Five-channel RS-485 polling master feeding a bi-phase Orbita M16 frame.
// One request per poll, collect replies, then serialise sync + 90 bytes.
module orb_m16 #(
  parameter int          BAUD_NUM    = 3,
  parameter int          BAUD_DEN    = 50,
  parameter int          POLL_PERIOD = 16384,
  parameter int          RX_WINDOW   = 4000,
  parameter int          ORB_HALF    = 8,
  parameter logic [7:0]  REQ_BYTE    = 8'hA5,
  parameter int          NBYTES      = 18,
  parameter logic [7:0]  SYNC_BYTE   = 8'h7E
) (
  input  logic       clk80MHz,
  input  logic       rst,
  orb_m16_if.master  bus,
  output logic       doubleOrbData,
  output logic       ValRX,
  output logic       test1,
  output logic       test2,
  output logic       test3,
  output logic       test4
);
  localparam int NCH  = 5;
  localparam int NBUF = NCH * NBYTES;
  localparam int NFRM = NBUF + 1;
  localparam int AW   = $clog2(BAUD_DEN + BAUD_NUM + 1);
  localparam int PW   = $clog2(POLL_PERIOD);
  localparam int WW   = $clog2(RX_WINDOW + 1);
  localparam int HW   = $clog2(ORB_HALF + 1);
  localparam int FW   = $clog2(NFRM + 1);
  localparam int CW   = $clog2(NBYTES + 1);

  typedef enum logic [2:0] {
    IDLE, TXREQ, RXWIN, LATCH, SER
  } state_t;

  state_t state, state_nx;

  logic [PW-1:0] poll_cnt;
  logic          poll_go;

  assign poll_go = poll_cnt == PW'(POLL_PERIOD - 1);

  always_ff @(posedge clk80MHz or negedge rst)
    if (!rst) poll_cnt <= '0;
    else      poll_cnt <= poll_go ? '0 : poll_cnt + 1'b1;

  always_ff @(posedge clk80MHz or negedge rst)
    if (!rst) test3 <= 1'b0;
    else      test3 <= poll_go;

  logic [AW-1:0] tx_acc, tx_sum;
  logic [3:0]    tx_bit;
  logic [9:0]    tx_frm;
  logic          tx_tick, tx_done, tx_line;

  assign tx_sum  = tx_acc + AW'(BAUD_NUM);
  assign tx_tick = tx_sum >= AW'(BAUD_DEN);
  assign tx_done = state == TXREQ && tx_tick && tx_bit == 4'd9;
  assign tx_frm  = {1'b1, REQ_BYTE, 1'b0};
  assign tx_line = tx_frm[tx_bit];

  always_ff @(posedge clk80MHz or negedge rst)
    if (!rst) begin
      tx_acc <= '0;
      tx_bit <= '0;
    end else if (poll_go || state != TXREQ) begin
      tx_acc <= '0;
      tx_bit <= '0;
    end else if (tx_tick) begin
      tx_acc <= tx_sum - AW'(BAUD_DEN);
      tx_bit <= tx_bit + 1'b1;
    end else begin
      tx_acc <= tx_sum;
    end

  assign bus.UART_TX  = state == TXREQ ? {NCH{tx_line}} : '1;
  assign bus.UART_dTX = state == TXREQ ? '1 : '0;
  assign bus.UART_dRX = state == TXREQ ? '1 : '0;

  logic [WW-1:0] win_cnt;
  logic          win_done;

  assign win_done = state == RXWIN && win_cnt == WW'(RX_WINDOW - 1);

  always_ff @(posedge clk80MHz or negedge rst)
    if (!rst)                win_cnt <= '0;
    else if (state != RXWIN) win_cnt <= '0;
    else                     win_cnt <= win_cnt + 1'b1;

  logic [2:0]    rx_sy  [NCH];
  logic [AW-1:0] rx_acc [NCH];
  logic [AW-1:0] rx_sum [NCH];
  logic [3:0]    rx_tk  [NCH];
  logic [7:0]    rx_sh  [NCH];
  logic [CW-1:0] rx_cnt [NCH];
  logic [NCH-1:0] busy, err;
  logic [7:0]    buffer [NBUF];
  logic          all_ok;

  always_ff @(posedge clk80MHz or negedge rst)
    if (!rst)
      for (int c = 0; c < NCH; c++) rx_sy[c] <= '1;
    else
      for (int c = 0; c < NCH; c++)
        rx_sy[c] <= {rx_sy[c][1:0], bus.UART_RX[c+1]};

  always_comb
    for (int c = 0; c < NCH; c++)
      rx_sum[c] = rx_acc[c] + AW'(BAUD_NUM);

  // rx_sy[1] is the synchronised line; rx_sy[2] lags it for edge detect
  always_ff @(posedge clk80MHz or negedge rst)
    if (!rst) begin
      busy  <= '0;
      err   <= '0;
      test1 <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        rx_acc[c] <= '0;
        rx_tk[c]  <= '0;
        rx_sh[c]  <= '0;
        rx_cnt[c] <= '0;
      end
      for (int i = 0; i < NBUF; i++) buffer[i] <= '0;
    end else begin
      test1 <= 1'b0;
      if (poll_go) begin
        busy <= '0;
        err  <= '0;
        for (int c = 0; c < NCH; c++) rx_cnt[c] <= '0;
        for (int i = 0; i < NBUF; i++) buffer[i] <= '0;
      end else begin
        for (int c = 0; c < NCH; c++) begin
          if (state != RXWIN) begin
            busy[c] <= 1'b0;
          end else if (!busy[c]) begin
            if (rx_sy[c][2] && !rx_sy[c][1]) begin
              busy[c]   <= 1'b1;
              rx_acc[c] <= AW'(BAUD_DEN / 2);
              rx_tk[c]  <= '0;
            end
          end else if (rx_sum[c] >= AW'(BAUD_DEN)) begin
            rx_acc[c] <= rx_sum[c] - AW'(BAUD_DEN);
            rx_tk[c]  <= rx_tk[c] + 1'b1;
            unique case (1'b1)
              rx_tk[c] == 4'd0: begin
                if (rx_sy[c][1]) busy[c] <= 1'b0;
              end
              rx_tk[c] == 4'd9: begin
                busy[c] <= 1'b0;
                if (!rx_sy[c][1]) begin
                  err[c] <= 1'b1;
                end else begin
                  if (c == 0) test1 <= 1'b1;
                  if (rx_cnt[c] < CW'(NBYTES)) begin
                    buffer[c*NBYTES + int'(rx_cnt[c])] <= rx_sh[c];
                    rx_cnt[c] <= rx_cnt[c] + 1'b1;
                  end
                end
              end
              default: rx_sh[c] <= {rx_sy[c][1], rx_sh[c][7:1]};
            endcase
          end else begin
            rx_acc[c] <= rx_sum[c];
          end
        end
      end
    end

  assign test2 = |err;

  always_comb begin
    all_ok = ~|err;
    for (int c = 0; c < NCH; c++)
      if (rx_cnt[c] != CW'(NBYTES)) all_ok = 1'b0;
  end

  always_ff @(posedge clk80MHz or negedge rst)
    if (!rst)                ValRX <= 1'b0;
    else if (state == LATCH) ValRX <= all_ok;

  logic [HW-1:0] hcnt;
  logic          half;
  logic [2:0]    sbit;
  logic [FW-1:0] sbyte, sidx;
  logic [7:0]    sval;
  logic          ser_last;

  assign ser_last = half && hcnt == HW'(ORB_HALF - 1) &&
                    sbit == 3'd7 && sbyte == FW'(NFRM - 1);
  assign sidx = sbyte == '0 ? '0 : sbyte - 1'b1;
  assign sval = sbyte == '0 ? SYNC_BYTE : buffer[sidx];

  always_ff @(posedge clk80MHz or negedge rst)
    if (!rst) begin
      hcnt  <= '0;
      half  <= 1'b0;
      sbit  <= '0;
      sbyte <= '0;
    end else if (state != SER) begin
      hcnt  <= '0;
      half  <= 1'b0;
      sbit  <= '0;
      sbyte <= '0;
    end else if (hcnt == HW'(ORB_HALF - 1)) begin
      hcnt <= '0;
      half <= ~half;
      if (half) begin
        sbit <= sbit + 1'b1;
        if (sbit == 3'd7) sbyte <= sbyte + 1'b1;
      end
    end else begin
      hcnt <= hcnt + 1'b1;
    end

  assign doubleOrbData = state == SER && (sval[3'd7 - sbit] ^ half);
  assign test4 = state == SER;

  always_ff @(posedge clk80MHz or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nx;

  // a poll wrap always wins, even over an unfinished frame
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = IDLE;
      TXREQ:   if (tx_done)  state_nx = RXWIN;
      RXWIN:   if (win_done) state_nx = LATCH;
      LATCH:   state_nx = SER;
      SER:     if (ser_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (poll_go) state_nx = TXREQ;
  end
endmodule

// File: tb/tb_orb_m16.sv
// Bench for orb_m16: slave reply models, request timing, frame decode.
// Expected frame bytes are queued per poll and popped as they decode.
`timescale 1ns/1ps
module tb_orb_m16;
  localparam int P   = 8192;
  localparam int H   = 2;
  localparam int RXW = 4000;
  localparam int NB  = 18;
  localparam int BN  = 3;
  localparam int BD  = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dod, valrx, t1, t2, t3, t4;

  always #6.25 clk = ~clk;

  orb_m16_if bus ();

  orb_m16 #(
    .POLL_PERIOD (P),
    .RX_WINDOW   (RXW),
    .ORB_HALF    (H)
  ) dut (
    .clk80MHz      (clk),
    .rst           (rst_n),
    .bus           (bus),
    .doubleOrbData (dod),
    .ValRX         (valrx),
    .test1         (t1),
    .test2         (t2),
    .test3         (t3),
    .test4         (t4)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  int cfg_nb  [1:5];
  int cfg_bad [1:5];

  int   r_t1;
  int   r_bp;
  logic r_val;
  logic r_err;

  task automatic bit_wait(inout int acc);
    do begin
      @(negedge clk);
      acc += BN;
    end while (acc < BD);
    acc -= BD;
  endtask

  task automatic send_ch(input int ch, input int n, input int bad);
    int acc = 0;
    logic [7:0] d;
    bus.UART_RX[ch] = 1'b1;
    repeat (30) bit_wait(acc);
    for (int i = 0; i < n; i++) begin
      d = 8'(i * 10);
      bus.UART_RX[ch] = 1'b0;
      bit_wait(acc);
      for (int k = 0; k < 8; k++) begin
        bus.UART_RX[ch] = d[k];
        bit_wait(acc);
      end
      bus.UART_RX[ch] = (i == bad) ? 1'b0 : 1'b1;
      bit_wait(acc);
      if (i == bad) begin
        bus.UART_RX[ch] = 1'b1;
        bit_wait(acc);
      end
    end
    bus.UART_RX[ch] = 1'b1;
  endtask

  function automatic void build_exp();
    int n;
    exp_q.delete();
    exp_q.push_back(8'h7E);
    for (int ch = 1; ch <= 5; ch++) begin
      n = 0;
      for (int i = 0; i < cfg_nb[ch]; i++)
        if (i != cfg_bad[ch] && n < NB) begin
          exp_q.push_back(8'(i * 10));
          n++;
        end
      for (; n < NB; n++) exp_q.push_back(8'h00);
    end
  endfunction

  function automatic void cfg_clean();
    for (int ch = 1; ch <= 5; ch++) begin
      cfg_nb[ch]  = NB;
      cfg_bad[ch] = -1;
    end
  endfunction

  task automatic sync_poll();
    int n = 0;
    while (bus.UART_dRX !== 5'h1F && n < 2 * P) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.UART_dRX !== 5'h1F) begin
      errors++;
      $display("FAIL poll_start got %b want 11111", bus.UART_dRX);
    end
    n = 0;
    while (bus.UART_dRX !== 5'h00 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.UART_dRX !== 5'h00) begin
      errors++;
      $display("FAIL req_end got %b want 00000", bus.UART_dRX);
    end
  endtask

  // called at the first negedge after dRX fell
  task automatic poll_body();
    logic [7:0] v, e;
    logic f, s;
    int n = 0;
    r_t1 = 0;
    r_bp = 0;
    build_exp();
    for (int ch = 1; ch <= 5; ch++) begin
      automatic int c = ch;
      fork
        send_ch(c, cfg_nb[c], cfg_bad[c]);
      join_none
    end
    while (t4 !== 1'b1 && n < RXW + 400) begin
      @(negedge clk);
      if (t1 === 1'b1) r_t1++;
      n++;
    end
    checks++;
    if (t4 !== 1'b1) begin
      errors++;
      $display("FAIL ser_start got %b want 1", t4);
      wait fork;
      return;
    end
    r_val = valrx;
    r_err = t2;
    for (int b = 0; b < 91; b++) begin
      v = '0;
      for (int k = 0; k < 8; k++) begin
        f = dod;
        repeat (H) @(negedge clk);
        s = dod;
        repeat (H) @(negedge clk);
        if (s === f) r_bp++;
        v = {v[6:0], f};
      end
      e = exp_q.pop_front();
      checks++;
      if (v !== e) begin
        errors++;
        $display("FAIL frame_byte%0d got %h want %h", b, v, e);
      end
    end
    checks++;
    if (r_bp != 0) begin
      errors++;
      $display("FAIL biphase got %0d bad want 0", r_bp);
    end
    checks++;
    if ({dod, t4} !== 2'b00) begin
      errors++;
      $display("FAIL ser_end got %b want 00", {dod, t4});
    end
    wait fork;
  endtask

  task automatic test_reset();
    int n = 0;
    bus.UART_RX = '1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.UART_TX !== 5'h1F || bus.UART_dTX !== 5'h00 ||
        bus.UART_dRX !== 5'h00) begin
      errors++;
      $display("FAIL reset_bus got %b %b %b want 11111 00000 00000",
               bus.UART_TX, bus.UART_dTX, bus.UART_dRX);
    end
    checks++;
    if ({dod, valrx, t1, t2, t3, t4} !== 6'b0) begin
      errors++;
      $display("FAIL reset_out got %b want 000000",
               {dod, valrx, t1, t2, t3, t4});
    end
    rst_n = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (bus.UART_dRX !== 5'h1F && n < 2 * P);
    checks++;
    if (n != P) begin
      errors++;
      $display("FAIL first_poll got %0d want %0d", n, P);
    end
  endtask

  task automatic test_request();
    logic [9:0] frm;
    logic b;
    frm = {1'b1, 8'hA5, 1'b0};
    checks++;
    if (t3 !== 1'b1) begin
      errors++;
      $display("FAIL test3_pulse got %b want 1", t3);
    end
    for (int j = 0; j < 167; j++) begin
      b = frm[(BN * j) / BD];
      checks++;
      if (bus.UART_TX !== {5{b}} || bus.UART_dTX !== 5'h1F ||
          bus.UART_dRX !== 5'h1F) begin
        errors++;
        $display("FAIL req_clk%0d got %b %b %b want %b 11111 11111",
                 j, bus.UART_TX, bus.UART_dTX, bus.UART_dRX, {5{b}});
      end
      @(negedge clk);
      if (j == 0) begin
        checks++;
        if (t3 !== 1'b0) begin
          errors++;
          $display("FAIL test3_len got %b want 0", t3);
        end
      end
    end
    checks++;
    if (bus.UART_TX !== 5'h1F || bus.UART_dTX !== 5'h00 ||
        bus.UART_dRX !== 5'h00) begin
      errors++;
      $display("FAIL req_fall got %b %b %b want 11111 00000 00000",
               bus.UART_TX, bus.UART_dTX, bus.UART_dRX);
    end
  endtask

  task automatic test_good();
    cfg_clean();
    poll_body();
    checks++;
    if ({r_val, r_err} !== 2'b10) begin
      errors++;
      $display("FAIL good_valrx got %b want 10", {r_val, r_err});
    end
    checks++;
    if (r_t1 != NB) begin
      errors++;
      $display("FAIL good_test1 got %0d want %0d", r_t1, NB);
    end
  endtask

  task automatic test_short_ch3();
    cfg_clean();
    cfg_nb[3] = 10;
    sync_poll();
    poll_body();
    checks++;
    if ({r_val, r_err} !== 2'b00) begin
      errors++;
      $display("FAIL short_valrx got %b want 00", {r_val, r_err});
    end
  endtask

  task automatic test_bad_stop();
    cfg_clean();
    cfg_bad[2] = 5;
    sync_poll();
    poll_body();
    checks++;
    if ({r_val, r_err} !== 2'b01) begin
      errors++;
      $display("FAIL badstop_valrx got %b want 01", {r_val, r_err});
    end
  endtask

  task automatic test_extra_ch1();
    cfg_clean();
    cfg_nb[1] = 20;
    sync_poll();
    poll_body();
    checks++;
    if ({r_val, r_err} !== 2'b10) begin
      errors++;
      $display("FAIL extra_valrx got %b want 10", {r_val, r_err});
    end
    checks++;
    if (r_t1 != 20) begin
      errors++;
      $display("FAIL extra_test1 got %0d want 20", r_t1);
    end
  endtask

  task automatic test_reset_ser();
    int n = 0;
    cfg_clean();
    sync_poll();
    for (int ch = 1; ch <= 5; ch++) begin
      automatic int c = ch;
      fork
        send_ch(c, NB, -1);
      join_none
    end
    while (!(t4 === 1'b1 && dod === 1'b1) && n < RXW + 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({t4, dod} !== 2'b11) begin
      errors++;
      $display("FAIL ser_high got %b want 11", {t4, dod});
    end
    wait fork;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dod, t4, valrx} !== 3'b000 || bus.UART_TX !== 5'h1F) begin
      errors++;
      $display("FAIL ser_abort got %b %b want 000 11111",
               {dod, t4, valrx}, bus.UART_TX);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sync_poll();
    poll_body();
    checks++;
    if ({r_val, r_err} !== 2'b10) begin
      errors++;
      $display("FAIL after_rst_valrx got %b want 10", {r_val, r_err});
    end
  endtask

  initial begin
    test_reset();
    test_request();
    test_good();
    test_short_ch3();
    test_bad_stop();
    test_extra_ch1();
    test_reset_ser();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
